// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game constants, enemy placement tables, the enemy
//                state encoding and the attack-box/enemy overlap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        DEAD  = 2'd2
    } enemy_state_t;

    localparam int SQUARE_SIDE   = 60;
    localparam int ATTACK_WIDTH  = 20;
    localparam int ATTACK_HEIGHT = 40;

    localparam logic UPDOWN    = 1'b0;
    localparam logic LEFTRIGHT = 1'b1;

    localparam logic [11:0] NO_ATTACK_X = 12'd1025;

    localparam logic [11:0] ENEMY_X [4] = '{12'd182, 12'd782, 12'd182, 12'd782};
    localparam logic [11:0] ENEMY_Y [4] = '{12'd108, 12'd108, 12'd468, 12'd468};

    // Half-open rectangle intersection, widened to 13 bits so ax+w and
    // ex+60 never wrap. Edges that merely touch do not overlap.
    function automatic logic box_overlap(
        input logic [11:0] ax,
        input logic [11:0] ay,
        input logic        dir,
        input logic [11:0] ex,
        input logic [11:0] ey
    );
        logic [12:0] w;
        logic [12:0] h;
        logic [12:0] side;
        w    = (dir == LEFTRIGHT) ? 13'(ATTACK_HEIGHT) : 13'(ATTACK_WIDTH);
        h    = (dir == LEFTRIGHT) ? 13'(ATTACK_WIDTH)  : 13'(ATTACK_HEIGHT);
        side = 13'(SQUARE_SIDE);
        return ({1'b0, ax} < ({1'b0, ex} + side)) &&
               ({1'b0, ex} < ({1'b0, ax} + w))    &&
               ({1'b0, ay} < ({1'b0, ey} + side)) &&
               ({1'b0, ey} < ({1'b0, ay} + h));
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_slot.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_slot
//  Description : One enemy: overlap test against both hero attack boxes and
//                the ALIVE -> DYING -> DEAD -> ALIVE life-cycle sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_slot
    import game_pkg::*;
#(
    parameter int          DYING_TIME   = 30,
    parameter int          RESPAWN_TIME = 300,
    parameter int          CNT_W        = 9,
    parameter logic [11:0] POS_X        = 12'd182,
    parameter logic [11:0] POS_Y        = 12'd108
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic [23:0] x_pos_attack,
    input  logic [23:0] y_pos_attack,
    input  logic        attack_direction,
    output logic        enemy_alive,
    output logic        enemy_visible,
    output logic        kill
);

    enemy_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_i;

    // Either hero's box touching this enemy counts as a single hit.
    always_comb begin
        hit_i = box_overlap(x_pos_attack[11:0],  y_pos_attack[11:0],
                            attack_direction, POS_X, POS_Y) |
                box_overlap(x_pos_attack[23:12], y_pos_attack[23:12],
                            attack_direction, POS_X, POS_Y);
    end

    // State and phase counter; reset brings the enemy back alive at once.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q <= ALIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; hits outside ALIVE are ignored so a held attack
    // can score only once per enemy life.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill    = 1'b0;
        case (state_q)
            ALIVE: begin
                if (hit_i) begin
                    kill    = 1'b1;
                    state_d = DYING;
                    cnt_d   = '0;
                end
            end
            DYING: begin
                if (cnt_q == CNT_W'(DYING_TIME - 1)) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEAD: begin
                if (cnt_q == CNT_W'(RESPAWN_TIME - 1)) begin
                    state_d = ALIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ALIVE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sprite controls from registered state only; blink is 4 on / 4 off.
    always_comb begin
        enemy_alive   = (state_q == ALIVE);
        enemy_visible = 1'b0;
        case (state_q)
            ALIVE:   enemy_visible = 1'b1;
            DYING:   enemy_visible = ~cnt_q[2];
            default: enemy_visible = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/enemy_hit_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_hit_ctl
//  Description : Enemy hit controller: per-enemy slots plus kill summation,
//                saturating 16-bit score and a one-tick hit pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_hit_ctl
    import game_pkg::*;
#(
    parameter int NUM_ENEMIES  = 4,
    parameter int DYING_TIME   = 30,
    parameter int RESPAWN_TIME = 300
) (
    input  logic                   clk_div,
    input  logic                   rst,
    input  logic [23:0]            x_pos_attack,
    input  logic [23:0]            y_pos_attack,
    input  logic                   attack_direction,
    output logic [NUM_ENEMIES-1:0] enemy_alive,
    output logic [NUM_ENEMIES-1:0] enemy_visible,
    output logic                   hit,
    output logic [15:0]            score
);

    localparam int MAX_T = (DYING_TIME > RESPAWN_TIME) ? DYING_TIME : RESPAWN_TIME;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int KW    = $clog2(NUM_ENEMIES + 1);

    logic [NUM_ENEMIES-1:0] kill;
    logic [KW-1:0]          kills;
    logic [16:0]            sum;
    logic [15:0]            score_q, score_d;
    logic                   hit_q, hit_d;

    generate
        for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
            enemy_slot #(
                .DYING_TIME   (DYING_TIME),
                .RESPAWN_TIME (RESPAWN_TIME),
                .CNT_W        (CNT_W),
                .POS_X        (ENEMY_X[i]),
                .POS_Y        (ENEMY_Y[i])
            ) u_slot (
                .clk_div          (clk_div),
                .rst              (rst),
                .x_pos_attack     (x_pos_attack),
                .y_pos_attack     (y_pos_attack),
                .attack_direction (attack_direction),
                .enemy_alive      (enemy_alive[i]),
                .enemy_visible    (enemy_visible[i]),
                .kill             (kill[i])
            );
        end
    endgenerate

    // Count kills this tick and add them to the score, clamping at all-ones.
    always_comb begin
        kills = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            kills = kills + KW'(kill[i]);
        end
        sum     = {1'b0, score_q} + 17'(kills);
        score_d = sum[16] ? 16'hFFFF : sum[15:0];
        hit_d   = |kill;
    end

    // Score and hit-pulse registers.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            score_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            score_q <= score_d;
            hit_q   <= hit_d;
        end
    end

    assign score = score_q;
    assign hit   = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_hit_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_hit_ctl
//  Description : Directed self-checking bench for enemy_hit_ctl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_hit_ctl;

    logic        clk_div;
    logic        rst;
    logic [23:0] x_pos_attack;
    logic [23:0] y_pos_attack;
    logic        attack_direction;
    logic [3:0]  enemy_alive;
    logic [3:0]  enemy_visible;
    logic        hit;
    logic [15:0] score;

    int err_cnt;
    int chk_cnt;

    enemy_hit_ctl #(
        .NUM_ENEMIES  (4),
        .DYING_TIME   (30),
        .RESPAWN_TIME (300)
    ) dut (
        .clk_div          (clk_div),
        .rst              (rst),
        .x_pos_attack     (x_pos_attack),
        .y_pos_attack     (y_pos_attack),
        .attack_direction (attack_direction),
        .enemy_alive      (enemy_alive),
        .enemy_visible    (enemy_visible),
        .hit              (hit),
        .score            (score)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    task automatic set_boxes(input logic [11:0] ax, input logic [11:0] ay,
                             input logic [11:0] bx, input logic [11:0] by,
                             input logic dir);
        x_pos_attack     = {bx, ax};
        y_pos_attack     = {by, ay};
        attack_direction = dir;
    endtask

    task automatic idle_boxes();
        set_boxes(12'd1025, 12'd0, 12'd1025, 12'd0, 1'b0);
    endtask

    // Asynchronous reset pulse applied between clock edges.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_alive"},   32'(enemy_alive),   32'hF);
        check({tag, "_visible"}, 32'(enemy_visible), 32'hF);
        check({tag, "_score"},   32'(score),         32'h0);
        check({tag, "_hit"},     32'(hit),           32'h0);
        rst = 1'b0;
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst     = 1'b0;
        idle_boxes();

        // Reset from power-up.
        #1;
        pulse_reset("rst0");
        tick(1);

        // Basic kill on enemy 0, held for 60 ticks.
        set_boxes(12'd202, 12'd148, 12'd1025, 12'd0, 1'b0);
        tick(1);
        check("kill_alive", 32'(enemy_alive), 32'hE);
        check("kill_hit",   32'(hit),         32'h1);
        check("kill_score", 32'(score),       32'h1);
        for (int j = 0; j < 30; j++) begin
            if (j != 0) tick(1);
            check($sformatf("blink%0d", j), 32'(enemy_visible[0]), ((j / 4) % 2 == 0) ? 32'h1 : 32'h0);
        end
        check("blink_hit_once", 32'(hit), 32'h0);
        tick(1);
        check("dead_visible", 32'(enemy_visible), 32'hE);
        check("dead_alive",   32'(enemy_alive),   32'hE);
        tick(29);
        check("dead_hold_score", 32'(score), 32'h1);
        check("dead_hold_hit",   32'(hit),   32'h0);
        idle_boxes();

        // Respawn exactly 330 ticks after the kill edge.
        tick(270);
        check("respawn_329", 32'(enemy_alive), 32'hE);
        tick(1);
        check("respawn_330_alive", 32'(enemy_alive),   32'hF);
        check("respawn_330_vis",   32'(enemy_visible), 32'hF);

        // Edge touch with LEFTRIGHT box: 242 touches, 241 overlaps.
        set_boxes(12'd242, 12'd120, 12'd1025, 12'd0, 1'b1);
        tick(1);
        check("touch_hit",   32'(hit),         32'h0);
        check("touch_alive", 32'(enemy_alive), 32'hF);
        set_boxes(12'd241, 12'd120, 12'd1025, 12'd0, 1'b1);
        tick(1);
        check("edge_hit",   32'(hit),         32'h1);
        check("edge_score", 32'(score),       32'h2);
        check("edge_alive", 32'(enemy_alive), 32'hE);
        idle_boxes();
        tick(3);

        // Reset while enemy 0 is dying.
        pulse_reset("rst_mid");
        tick(1);

        // Two enemies in one tick, then both heroes on one enemy.
        set_boxes(12'd202, 12'd148, 12'd802, 12'd488, 1'b0);
        tick(1);
        check("dual_score", 32'(score),       32'h2);
        check("dual_hit",   32'(hit),         32'h1);
        check("dual_alive", 32'(enemy_alive), 32'h6);
        tick(1);
        check("dual_hit_drop", 32'(hit),   32'h0);
        check("dual_hold",     32'(score), 32'h2);
        set_boxes(12'd802, 12'd148, 12'd790, 12'd150, 1'b0);
        tick(1);
        check("same_score", 32'(score),       32'h3);
        check("same_hit",   32'(hit),         32'h1);
        check("same_alive", 32'(enemy_alive), 32'h4);
        idle_boxes();

        // Saturation from a preloaded score.
        pulse_reset("rst_sat");
        tick(1);
        force dut.score_q = 16'hFFFE;
        #1;
        release dut.score_q;
        check("preload", 32'(score), 32'hFFFE);
        set_boxes(12'd202, 12'd148, 12'd802, 12'd488, 1'b0);
        tick(1);
        check("sat_score", 32'(score), 32'hFFFF);
        check("sat_hit",   32'(hit),   32'h1);
        set_boxes(12'd202, 12'd488, 12'd802, 12'd148, 1'b0);
        tick(1);
        check("sat_hold_score", 32'(score),       32'hFFFF);
        check("sat_hold_alive", 32'(enemy_alive), 32'h0);
        idle_boxes();

        // Idle boxes for 1000 ticks: nothing may change.
        pulse_reset("rst_idle");
        for (int j = 0; j < 10; j++) begin
            tick(100);
            check($sformatf("idle%0d_alive", j), 32'(enemy_alive), 32'hF);
            check($sformatf("idle%0d_score", j), 32'(score),       32'h0);
            check($sformatf("idle%0d_hit", j),   32'(hit),         32'h0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enemy_hit_ctl.md
# enemy_hit_ctl

Consumes the two packed attack boxes produced by the hero controller on `clk_div`. Each tick it tests them against a fixed set of enemies, and sequences every enemy through alive, dying-blink and respawn. It counts kills into a saturating score. Outputs feed the enemy sprite renderer and the score display.

## Interface
- `NUM_ENEMIES`, default 4: number of enemy slots; must be ≤ length of the package position tables.
- `DYING_TIME`, default 30: ticks an enemy spends blinking after a hit.
- `RESPAWN_TIME`, default 300: ticks an enemy stays absent before reappearing.

- `clk_div`, input, 1: game tick clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `x_pos_attack`, input, 24: attack box left edge; [11:0] is hero A, [23:12] is hero B; value 1025 means no attack.
- `y_pos_attack`, input, 24: attack box top edge, same packing.
- `attack_direction`, input, 1: 0 = UPDOWN, box 20 wide × 40 high; 1 = LEFTRIGHT, box 40 wide × 20 high; applies to both boxes.
- `enemy_alive`, output, NUM_ENEMIES: 1 when slot is ALIVE.
- `enemy_visible`, output, NUM_ENEMIES: sprite draw enable, including blink.
- `hit`, output, 1: one-tick pulse on any kill.
- `score`, output, 16: kill count, unsigned, saturating at 16'hFFFF.

## Operation
Each slot runs a three-state FSM: ALIVE → DYING → DEAD → ALIVE.

**Enemy geometry**
- Each enemy is a 60×60 square at (`ENEMY_X[i]`, `ENEMY_Y[i]`) from the package.

**Overlap test**
- Half-open intervals: box [ax, ax+w) × [ay, ay+h) against [ex, ex+60) × [ey, ey+60).
- Overlap iff ax < ex+60 && ex < ax+w && ay < ey+60 && ey < ay+h.
- All 12-bit unsigned, evaluated in 13 bits so no compare wraps.
- Touching edges (ax == ex+60) is not a hit.
- A box at x = 1025 can never overlap, since enemies lie within 62..962.
- `hit_i` = overlap with box A OR overlap with box B.

**FSM transitions**
- ALIVE: on `hit_i`, go to DYING with counter = 0.
- DYING: counter increments each tick. When counter == DYING_TIME−1, go to DEAD with counter = 0.
- DEAD: counter increments each tick. When counter == RESPAWN_TIME−1, go to ALIVE with counter = 0.
- Overlaps during DYING or DEAD are ignored. A 60-tick attack therefore scores at most once per enemy.

**Outputs**
- `enemy_alive[i]` = (state == ALIVE).
- `enemy_visible[i]` is 1 in ALIVE, `~counter[2]` in DYING (4 ticks on, 4 ticks off, starting on), and 0 in DEAD.
- Both are decoded from registers only; there is no input-to-output path.

**Scoring**
- k = number of slots going ALIVE→DYING at this edge.
- score ← min(score + k, 16'hFFFF).
- hit ← (k ≠ 0).

**Simultaneous events**
- Both heroes hitting one enemy in the same tick counts as one kill.
- Two enemies hit in the same tick gives score +2 and a single `hit` pulse.

## Timing
- Reset (async, immediate) sets all slots to ALIVE with counter 0: `enemy_alive` = all 1, `enemy_visible` = all 1, `hit` = 0, `score` = 0.
- Reset mid-DYING or mid-DEAD returns the slot to ALIVE immediately.
- Latency: inputs sampled at edge n produce updated `enemy_alive`, `score` and `hit` after edge n (1 tick).
- `hit` is high for exactly one tick per kill edge.
- Time in DYING is exactly DYING_TIME ticks; time in DEAD is exactly RESPAWN_TIME ticks.
- Counter width is $clog2(max(DYING_TIME, RESPAWN_TIME)).

## Structure
- Shared package `game_pkg` holds:
  - state enum {ALIVE, DYING, DEAD};
  - SQUARE_SIDE = 60, ATTACK_WIDTH = 20, ATTACK_HEIGHT = 40;
  - UPDOWN = 0, LEFTRIGHT = 1;
  - NO_ATTACK_X = 1025;
  - ENEMY_X = {182, 782, 182, 782}, ENEMY_Y = {108, 108, 468, 468}.
- Sub-module `enemy_slot`: one FSM, counter and overlap test. It is instantiated NUM_ENEMIES times via generate.
- The top level does the kill summation, the saturating score and `hit`.

## Test plan
- **Reset:** assert `rst` mid-run → `enemy_alive` = 4'b1111, `enemy_visible` = 4'b1111, `score` = 0, `hit` = 0 with no clock edge needed.
- **Basic kill:** box A at (202, 148), dir UPDOWN, held 60 ticks → `enemy_alive[0]` = 0 one tick later, `hit` pulses once, `score` = 1. `enemy_visible[0]` pattern is 1111 0000 … for 30 ticks, then 0.
- **Edge touch:** box A at (242, 120), dir LEFTRIGHT → no hit. Box at (241, 120) → hit on enemy 0.
- **Respawn:** after a kill, `enemy_alive[0]` returns to 1 exactly 330 ticks after the hit tick. A second overlap during DEAD leaves `score` unchanged.
- **Simultaneous kills:** box A on enemy 0 and box B at (802, 488) on enemy 3 in the same tick → `score` +2, single `hit` pulse. Both boxes on enemy 0 → `score` +1.
- **Saturation and idle:** preload `score` to 16'hFFFE, kill two enemies in one tick → `score` = 16'hFFFF. Boxes at 1025/0 → no change for 1000 ticks.
